// File: rtl/reservation_station_pkg.sv
// Shared types and parameters for the reservation station slice.
//   RS_SIZE  : number of station entries
//   TAG_W    : ROB tag width; tag 0 means "no dependency" on operands and "idle" on the CDB
//   XLEN     : operand value width
// capture_operand() resolves one source operand at allocation time.
package reservation_station_pkg;

    localparam int RS_SIZE = 8;
    localparam int TAG_W   = 4;
    localparam int XLEN    = 32;

    typedef struct packed {
        logic [TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]  value;
    } CDB_DATA;

    typedef struct packed {
        logic [7:0]      opcode;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
    } ID_EX_PACKET;

    typedef struct packed {
        logic [TAG_W-1:0] rob_tag_val;
        logic             rob_tag_ready;
    } MAPTABLE_PACKET;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] rd_tag;
        logic [TAG_W-1:0] rs1_tag;
        logic [TAG_W-1:0] rs2_tag;
        logic [XLEN-1:0]  rs1_value;
        logic [XLEN-1:0]  rs2_value;
        ID_EX_PACKET      id_packet;
    } INSTR_READY_ENTRY;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] rd_tag;
        logic [TAG_W-1:0] rs1_tag;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs1_ready;
        logic             rs2_ready;
        logic [XLEN-1:0]  rs1_value;
        logic [XLEN-1:0]  rs2_value;
        ID_EX_PACKET      id_packet;
    } RS_ENTRY;

    // Returns {ready, value}. The register file value wins when the map table
    // says the producer is done; otherwise a same-cycle CDB broadcast of the
    // tag is forwarded so the result is not missed during allocation.
    function automatic logic [XLEN:0] capture_operand(
        input logic [TAG_W-1:0] tag,
        input logic             tag_ready,
        input logic [XLEN-1:0]  reg_value,
        input CDB_DATA          bus
    );
        if (tag == '0 || tag_ready) begin
            return {1'b1, reg_value};
        end
        if (bus.rob_tag != '0 && bus.rob_tag == tag) begin
            return {1'b1, bus.value};
        end
        return '0;
    endfunction

endpackage

// File: rtl/reservation_station_priority_enc.sv
// Lowest-index one-hot selector.
//   req   : request vector
//   grant : one-hot vector with the lowest set bit of req, or zero if req is zero
module reservation_station_priority_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    // Scanning from the top down lets the lowest requester overwrite any higher one.
    always_comb begin
        grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: captures renamed instructions, wakes operands
// from the CDB and presents the lowest-index ready entry to the execute unit.
//   clk, reset            : clock, synchronous active-low reset
//   cdb                   : result broadcast {rob_tag, value}; rob_tag 0 = idle
//   enable                : allocate the current instruction (dropped when rs_full)
//   id_packet_out         : decoded instruction with register file operand values
//   maptable_packet_rs1/2 : producer tag and readiness for each source
//   alloc_slot            : destination ROB tag
//   rs_full               : every entry busy
//   ready_inst_entry      : instruction issued this cycle (all zero when none)
// Issue has no back-pressure: a valid ready_inst_entry is consumed by the
// execute unit in that cycle and the entry is released at the following edge.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  CDB_DATA          cdb,
    input  logic             enable,
    input  ID_EX_PACKET      id_packet_out,
    input  MAPTABLE_PACKET   maptable_packet_rs1,
    input  MAPTABLE_PACKET   maptable_packet_rs2,
    input  logic [TAG_W-1:0] alloc_slot,
    output logic             rs_full,
    output INSTR_READY_ENTRY ready_inst_entry
);

    RS_ENTRY            entries_q [RS_SIZE];
    RS_ENTRY            entries_d [RS_SIZE];
    RS_ENTRY            new_entry;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] free_grant;
    logic [RS_SIZE-1:0] issue_grant;
    logic [XLEN:0]      rs1_cap;
    logic [XLEN:0]      rs2_cap;
    logic               cdb_live;

    assign cdb_live = (cdb.rob_tag != '0);

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !entries_q[i].busy;
            ready_vec[i] = entries_q[i].busy && entries_q[i].rs1_ready && entries_q[i].rs2_ready;
        end
    end

    // Full is taken from the registered busy bits only, so an entry issuing
    // this cycle does not make room for an allocation on the same edge.
    assign rs_full = ~|free_vec;

    reservation_station_priority_enc #(.N(RS_SIZE)) u_free_sel (
        .req   (free_vec),
        .grant (free_grant)
    );

    reservation_station_priority_enc #(.N(RS_SIZE)) u_issue_sel (
        .req   (ready_vec),
        .grant (issue_grant)
    );

    always_comb begin
        rs1_cap = capture_operand(maptable_packet_rs1.rob_tag_val, maptable_packet_rs1.rob_tag_ready,
                                  id_packet_out.rs1_value, cdb);
        rs2_cap = capture_operand(maptable_packet_rs2.rob_tag_val, maptable_packet_rs2.rob_tag_ready,
                                  id_packet_out.rs2_value, cdb);
        new_entry           = '0;
        new_entry.busy      = 1'b1;
        new_entry.rd_tag    = alloc_slot;
        new_entry.rs1_tag   = maptable_packet_rs1.rob_tag_val;
        new_entry.rs2_tag   = maptable_packet_rs2.rob_tag_val;
        new_entry.rs1_ready = rs1_cap[XLEN];
        new_entry.rs2_ready = rs2_cap[XLEN];
        new_entry.rs1_value = rs1_cap[XLEN-1:0];
        new_entry.rs2_value = rs2_cap[XLEN-1:0];
        new_entry.id_packet = id_packet_out;
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].busy) begin
                // Tags stay untouched on wakeup so the issued entry still shows its producers.
                if (cdb_live && !entries_q[i].rs1_ready && entries_q[i].rs1_tag == cdb.rob_tag) begin
                    entries_d[i].rs1_ready = 1'b1;
                    entries_d[i].rs1_value = cdb.value;
                end
                if (cdb_live && !entries_q[i].rs2_ready && entries_q[i].rs2_tag == cdb.rob_tag) begin
                    entries_d[i].rs2_ready = 1'b1;
                    entries_d[i].rs2_value = cdb.value;
                end
                if (issue_grant[i]) begin
                    entries_d[i].busy = 1'b0;
                end
            end else if (enable && !rs_full && free_grant[i]) begin
                entries_d[i] = new_entry;
            end
        end
    end

    always_comb begin
        ready_inst_entry = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (issue_grant[i]) begin
                ready_inst_entry.valid     = 1'b1;
                ready_inst_entry.rd_tag    = entries_q[i].rd_tag;
                ready_inst_entry.rs1_tag   = entries_q[i].rs1_tag;
                ready_inst_entry.rs2_tag   = entries_q[i].rs2_tag;
                ready_inst_entry.rs1_value = entries_q[i].rs1_value;
                ready_inst_entry.rs2_value = entries_q[i].rs2_value;
                ready_inst_entry.id_packet = entries_q[i].id_packet;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!reset) begin
                entries_q[i] <= '0;
            end else begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a table of per-cycle vectors for the
// single-instruction paths, then hand-written fill/drain and ordering sequences.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic             clk;
    logic             reset;
    CDB_DATA          cdb;
    logic             enable;
    ID_EX_PACKET      id_packet_out;
    MAPTABLE_PACKET   maptable_packet_rs1;
    MAPTABLE_PACKET   maptable_packet_rs2;
    logic [TAG_W-1:0] alloc_slot;
    logic             rs_full;
    INSTR_READY_ENTRY ready_inst_entry;

    int n_pass;
    int n_total;

    reservation_station dut (
        .clk                 (clk),
        .reset               (reset),
        .cdb                 (cdb),
        .enable              (enable),
        .id_packet_out       (id_packet_out),
        .maptable_packet_rs1 (maptable_packet_rs1),
        .maptable_packet_rs2 (maptable_packet_rs2),
        .alloc_slot          (alloc_slot),
        .rs_full             (rs_full),
        .ready_inst_entry    (ready_inst_entry)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each record: inputs driven after the check, expected outputs checked first
    // (they reflect the state built by the previous records).
    typedef struct {
        logic        en;
        logic [7:0]  op;
        logic [3:0]  r1t;
        logic        r1r;
        logic [31:0] r1v;
        logic [3:0]  r2t;
        logic        r2r;
        logic [31:0] r2v;
        logic [3:0]  slot;
        logic [3:0]  ct;
        logic [31:0] cv;
        logic        e_full;
        logic        e_valid;
        logic [3:0]  e_rd;
        logic [3:0]  e_t1;
        logic [3:0]  e_t2;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
        logic [7:0]  e_op;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    // driver tasks
    task automatic drive_idle();
        enable              = 1'b0;
        id_packet_out       = '0;
        maptable_packet_rs1 = '0;
        maptable_packet_rs2 = '0;
        alloc_slot          = '0;
        cdb                 = '0;
    endtask

    task automatic drive_alloc(input logic [7:0] op, input logic [3:0] r1t, input logic r1r,
                               input logic [31:0] r1v, input logic [3:0] r2t, input logic r2r,
                               input logic [31:0] r2v, input logic [3:0] slot);
        enable                            = 1'b1;
        id_packet_out.opcode              = op;
        id_packet_out.rs1_value           = r1v;
        id_packet_out.rs2_value           = r2v;
        maptable_packet_rs1.rob_tag_val   = r1t;
        maptable_packet_rs1.rob_tag_ready = r1r;
        maptable_packet_rs2.rob_tag_val   = r2t;
        maptable_packet_rs2.rob_tag_ready = r2r;
        alloc_slot                        = slot;
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
        cdb.rob_tag = tag;
        cdb.value   = val;
    endtask

    // scoreboard
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_issue(input string name, input logic ev, input logic [3:0] rd,
                               input logic [3:0] t1, input logic [3:0] t2, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [7:0] op);
        check({name, " valid"}, 128'(ready_inst_entry.valid), 128'(ev));
        check({name, " payload"},
              128'({ready_inst_entry.rd_tag, ready_inst_entry.rs1_tag, ready_inst_entry.rs2_tag,
                    ready_inst_entry.rs1_value, ready_inst_entry.rs2_value,
                    ready_inst_entry.id_packet.opcode}),
              128'({rd, t1, t2, v1, v2, op}));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        //          en op     r1t r1r r1v  r2t r2r r2v  slot ct cv   full vld rd t1 t2 v1  v2  op
        vecs[0]  = '{1, 8'h03, 0, 0, 5,   0, 0, 0,   1,   0, 0,   0, 0, 0, 0, 0, 0,  0,  8'h00};
        vecs[1]  = '{0, 8'h00, 0, 0, 0,   0, 0, 0,   0,   0, 0,   0, 1, 1, 0, 0, 5,  0,  8'h03};
        vecs[2]  = '{1, 8'h33, 0, 0, 10,  1, 0, 77,  2,   0, 0,   0, 0, 0, 0, 0, 0,  0,  8'h00};
        vecs[3]  = '{0, 8'h00, 0, 0, 0,   0, 0, 0,   0,   1, 5,   0, 0, 0, 0, 0, 0,  0,  8'h00};
        vecs[4]  = '{0, 8'h00, 0, 0, 0,   0, 0, 0,   0,   0, 0,   0, 1, 2, 0, 1, 10, 5,  8'h33};
        vecs[5]  = '{1, 8'h13, 0, 0, 3,   4, 0, 88,  5,   4, 9,   0, 0, 0, 0, 0, 0,  0,  8'h00};
        vecs[6]  = '{0, 8'h00, 0, 0, 0,   0, 0, 0,   0,   0, 0,   0, 1, 5, 0, 4, 3,  9,  8'h13};
        vecs[7]  = '{1, 8'h21, 6, 1, 11,  0, 0, 12,  6,   6, 99,  0, 0, 0, 0, 0, 0,  0,  8'h00};
        vecs[8]  = '{0, 8'h00, 0, 0, 0,   0, 0, 0,   0,   0, 0,   0, 1, 6, 6, 0, 11, 12, 8'h21};
        vecs[9]  = '{1, 8'h44, 3, 0, 1,   3, 0, 2,   7,   0, 0,   0, 0, 0, 0, 0, 0,  0,  8'h00};
        vecs[10] = '{0, 8'h00, 0, 0, 0,   0, 0, 0,   0,   3, 42,  0, 0, 0, 0, 0, 0,  0,  8'h00};
        vecs[11] = '{0, 8'h00, 0, 0, 0,   0, 0, 0,   0,   0, 0,   0, 1, 7, 3, 3, 42, 42, 8'h44};
        vecs[12] = '{0, 8'h00, 0, 0, 0,   0, 0, 0,   0,   0, 0,   0, 0, 0, 0, 0, 0,  0,  8'h00};

        // Reset with a ready instruction offered: nothing may be allocated.
        drive_idle();
        reset = 1'b0;
        drive_alloc(8'hEE, 0, 0, 32'd1, 0, 0, 32'd2, 4'd9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        check("reset rs_full", 128'(rs_full), 128'(0));
        check_issue("reset", 1'b0, 0, 0, 0, 0, 0, 0);

        // Table-driven single-instruction paths.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d rs_full", i), 128'(rs_full), 128'(vecs[i].e_full));
            check_issue($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_rd, vecs[i].e_t1,
                        vecs[i].e_t2, vecs[i].e_v1, vecs[i].e_v2, vecs[i].e_op);
            drive_idle();
            if (vecs[i].en) begin
                drive_alloc(vecs[i].op, vecs[i].r1t, vecs[i].r1r, vecs[i].r1v,
                            vecs[i].r2t, vecs[i].r2r, vecs[i].r2v, vecs[i].slot);
            end
            set_cdb(vecs[i].ct, vecs[i].cv);
        end

        // Fill all entries behind tag 7, which is not broadcast yet.
        for (int k = 0; k < RS_SIZE; k++) begin
            @(negedge clk);
            check($sformatf("fill%0d rs_full", k), 128'(rs_full), 128'(0));
            drive_idle();
            drive_alloc(8'(8'h50 + k), 0, 0, 32'(k), 7, 0, 0, 4'(8 + k));
        end
        @(negedge clk);
        check("full rs_full", 128'(rs_full), 128'(1));
        check_issue("full", 1'b0, 0, 0, 0, 0, 0, 0);
        drive_idle();
        drive_alloc(8'h99, 0, 0, 32'd1, 0, 0, 32'd2, 4'd1);   // dropped: station full
        @(negedge clk);
        check("dropped rs_full", 128'(rs_full), 128'(1));
        check_issue("dropped", 1'b0, 0, 0, 0, 0, 0, 0);
        drive_idle();
        set_cdb(7, 32'd123);
        for (int k = 0; k < RS_SIZE; k++) begin
            @(negedge clk);
            check($sformatf("drain%0d rs_full", k), 128'(rs_full), 128'(k == 0));
            check_issue($sformatf("drain%0d", k), 1'b1, 4'(8 + k), 0, 7, 32'(k), 32'd123,
                        8'(8'h50 + k));
            drive_idle();
            // Entry 0 frees on this edge but rs_full is still high: must be dropped.
            if (k == 0) drive_alloc(8'h77, 0, 0, 32'd555, 0, 0, 32'd0, 4'd3);
        end
        @(negedge clk);
        check("drained rs_full", 128'(rs_full), 128'(0));
        check_issue("drained", 1'b0, 0, 0, 0, 0, 0, 0);

        // Slots 0 and 3 become ready together: lowest index first.
        drive_alloc(8'hA0, 0, 0, 32'd1, 2, 0, 32'd0, 4'd1);
        @(negedge clk);
        drive_alloc(8'hA1, 0, 0, 32'd2, 5, 0, 32'd0, 4'd2);
        @(negedge clk);
        drive_alloc(8'hA2, 0, 0, 32'd3, 5, 0, 32'd0, 4'd3);
        @(negedge clk);
        drive_alloc(8'hA3, 0, 0, 32'd4, 2, 0, 32'd0, 4'd4);
        @(negedge clk);
        check_issue("order wait", 1'b0, 0, 0, 0, 0, 0, 0);
        drive_idle();
        set_cdb(2, 32'd66);
        @(negedge clk);
        check_issue("order slot0", 1'b1, 4'd1, 0, 2, 32'd1, 32'd66, 8'hA0);
        drive_idle();
        @(negedge clk);
        check_issue("order slot3", 1'b1, 4'd4, 0, 2, 32'd4, 32'd66, 8'hA3);
        @(negedge clk);
        check_issue("order done", 1'b0, 0, 0, 0, 0, 0, 0);
        check("order rs_full", 128'(rs_full), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
